// File: rtl/maxpool_seq_ctrl.sv
// Window sequencer for the 2x2 / stride-2 max-pooling datapath.
// Define MAXPOOL_SEQ_PERF_EN to add the perf_cycles busy-cycle counter output.
module maxpool_seq_ctrl #(
    parameter int unsigned IMG_W    = 28,
    parameter int unsigned IMG_H    = 28,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr0,
    output logic [ADDR_W-1:0] rd_addr1,
    output logic [ADDR_W-1:0] rd_addr2,
    output logic [ADDR_W-1:0] rd_addr3,
    output logic              mp_enable,
    output logic              mp_valid_in,
    output logic              mp_read,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
`ifdef MAXPOOL_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int unsigned DIM_MAX = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int unsigned CNT_W   = $clog2(DIM_MAX) + 1;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 2);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [PIPE_LAT:1]   v_q, v_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr0_q, rd_addr0_d;
    logic [ADDR_W-1:0]   rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0]   rd_addr2_q, rd_addr2_d;
    logic [ADDR_W-1:0]   rd_addr3_q, rd_addr3_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         base_d;
    logic                start_acc;
    logic                last_win;
    logic                pipe_drained;
    logic                rd_en_c;
    logic                wr_en_c;

    assign start_acc    = (state_q == S_IDLE) && start;
    assign last_win     = (col_q == COL_LAST) && (row_q == ROW_LAST);
    // Drained when nothing but the final write remains in flight.
    assign pipe_drained = (v_q[PIPE_LAT-1:1] == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; hold freezes the sequencer in RUN and DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (!hold && last_win) state_d = S_DRAIN;
            S_DRAIN: if (!hold && pipe_drained) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic for the read request and max-unit controls
    always_comb begin
        rd_en_c     = (state_q == S_RUN) && !hold;
        wr_en_c     = v_q[PIPE_LAT] && !hold;
        rd_en       = rd_en_c;
        wr_en       = wr_en_c;
        mp_enable   = busy_q && !hold;
        mp_valid_in = v_q[1];
        mp_read     = v_q[PIPE_LAT-1];
        busy        = busy_q;
        done        = done_q;
        rd_addr0    = rd_addr0_q;
        rd_addr1    = rd_addr1_q;
        rd_addr2    = rd_addr2_q;
        rd_addr3    = rd_addr3_q;
        wr_addr     = wr_addr_q;
    end

    // Window counters, valid pipeline and write address
    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        v_d       = v_q;
        wr_addr_d = wr_addr_q;
        if (start_acc) begin
            col_d     = '0;
            row_d     = '0;
            v_d       = '0;
            wr_addr_d = '0;
        end else if (!hold) begin
            v_d = {v_q[PIPE_LAT-1:1], rd_en_c};
            if (wr_en_c) begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
            if (rd_en_c) begin
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    row_d = (row_q == ROW_LAST) ? '0 : row_q + CNT_W'(2);
                end else begin
                    col_d = col_q + CNT_W'(2);
                end
            end
        end
    end

    // Registered window addresses for the window about to be issued
    always_comb begin
        base_d     = 32'(row_d) * IMG_W + 32'(col_d);
        rd_addr0_d = '0;
        rd_addr1_d = '0;
        rd_addr2_d = '0;
        rd_addr3_d = '0;
        if (state_d == S_RUN) begin
            rd_addr0_d = ADDR_W'(base_d);
            rd_addr1_d = ADDR_W'(base_d + 32'd1);
            rd_addr2_d = ADDR_W'(base_d + IMG_W);
            rd_addr3_d = ADDR_W'(base_d + IMG_W + 32'd1);
        end
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            v_q        <= '0;
            wr_addr_q  <= '0;
            rd_addr0_q <= '0;
            rd_addr1_q <= '0;
            rd_addr2_q <= '0;
            rd_addr3_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            v_q        <= v_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr0_q <= rd_addr0_d;
            rd_addr1_q <= rd_addr1_d;
            rd_addr2_q <= rd_addr2_d;
            rd_addr3_q <= rd_addr3_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

`ifdef MAXPOOL_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter, hold cycles included; kept after done
    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (busy_q) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Scoreboard bench for maxpool_seq_ctrl: 4x4 instance under random start/hold
// against a progress-count reference model, plus a directed 28x28 pass.
module tb_maxpool_seq_ctrl;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 10;
    localparam int PL = 4;
    localparam int K  = (W / 2) * (H / 2);
    localparam int W2 = 28;
    localparam int H2 = 28;
    localparam int K2 = (W2 / 2) * (H2 / 2);

    typedef struct {
        int          cyc;
        logic [AW-1:0] a0, a1, a2, a3;
    } rd_exp_t;
    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
    } wr_exp_t;
    typedef struct {
        int cyc;
        int perf;
    } done_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic busy, done, rd_en, mp_enable, mp_valid_in, mp_read, wr_en;
    logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, wr_addr;

    logic start_b = 1'b0;
    logic hold_b = 1'b0;
    logic b_busy, b_done, b_rd_en, b_mp_enable, b_mp_valid_in, b_mp_read, b_wr_en;
    logic [AW-1:0] b_rd_addr0, b_rd_addr1, b_rd_addr2, b_rd_addr3, b_wr_addr;
`ifdef MAXPOOL_SEQ_PERF_EN
    logic [31:0] perf_cycles, b_perf_cycles;
`endif

    maxpool_seq_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIPE_LAT(PL)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr0    (rd_addr0),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_addr3    (rd_addr3),
        .mp_enable   (mp_enable),
        .mp_valid_in (mp_valid_in),
        .mp_read     (mp_read),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr)
`ifdef MAXPOOL_SEQ_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    maxpool_seq_ctrl #(.IMG_W(W2), .IMG_H(H2), .ADDR_W(AW), .PIPE_LAT(PL)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start_b),
        .hold        (hold_b),
        .busy        (b_busy),
        .done        (b_done),
        .rd_en       (b_rd_en),
        .rd_addr0    (b_rd_addr0),
        .rd_addr1    (b_rd_addr1),
        .rd_addr2    (b_rd_addr2),
        .rd_addr3    (b_rd_addr3),
        .mp_enable   (b_mp_enable),
        .mp_valid_in (b_mp_valid_in),
        .mp_read     (b_mp_read),
        .wr_en       (b_wr_en),
        .wr_addr     (b_wr_addr)
`ifdef MAXPOOL_SEQ_PERF_EN
        ,
        .perf_cycles (b_perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_err = 0;

    rd_exp_t   rd_q[$];
    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    rd_exp_t   m_rd;
    wr_exp_t   m_wr;
    done_exp_t m_dn;

    // Reference model: progress = count of non-held cycles since start acceptance
    bit pass_on  = 1'b0;
    bit exp_busy = 1'b0;
    int p        = 0;
    int done_at  = -1;
    int busy_cnt = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push_rd(input int j);
        int row, col, base;
        rd_exp_t e;
        row   = 2 * (j / (W / 2));
        col   = 2 * (j % (W / 2));
        base  = row * W + col;
        e.cyc = cyc;
        e.a0  = AW'(base);
        e.a1  = AW'(base + 1);
        e.a2  = AW'(base + W);
        e.a3  = AW'(base + W + 1);
        rd_q.push_back(e);
    endtask

    task automatic step(input bit st, input bit hd);
        wr_exp_t   w;
        done_exp_t d;
        @(posedge clk);
        #1;
        start    = st;
        hold     = hd;
        exp_busy = pass_on;
        if (pass_on) begin
            busy_cnt++;
            if (!hd) begin
                p++;
                if (p <= K) push_rd(p - 1);
                if (p > PL && p <= K + PL) begin
                    w.cyc  = cyc;
                    w.addr = AW'(p - 1 - PL);
                    wr_q.push_back(w);
                end
                if (p == K + PL) begin
                    pass_on = 1'b0;
                    done_at = cyc + 1;
                end
            end
        end else if (done_at == cyc) begin
            d.cyc  = cyc;
            d.perf = busy_cnt;
            done_q.push_back(d);
            done_at = -1;
        end else if (st) begin
            pass_on  = 1'b1;
            p        = 0;
            busy_cnt = 0;
        end
    endtask

    task automatic reset_cycle(input int n);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        start    = 1'b0;
        hold     = 1'b0;
        pass_on  = 1'b0;
        exp_busy = 1'b0;
        done_at  = -1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr0", rd_addr0, 0);
        chk("rst_rd_addr1", rd_addr1, 0);
        chk("rst_rd_addr2", rd_addr2, 0);
        chk("rst_rd_addr3", rd_addr3, 0);
        chk("rst_mp_enable", mp_enable, 0);
        chk("rst_mp_valid_in", mp_valid_in, 0);
        chk("rst_mp_read", mp_read, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read, write or done
    always @(negedge clk) begin
        chk("busy", busy, exp_busy);
        chk("mp_enable", mp_enable, exp_busy && !hold);
        if (rd_en) begin
            if (rd_q.size() == 0) begin
                chk("rd_spurious", rd_en, 0);
            end else begin
                m_rd = rd_q.pop_front();
                chk("rd_cycle", cyc, m_rd.cyc);
                chk("rd_addr0", rd_addr0, m_rd.a0);
                chk("rd_addr1", rd_addr1, m_rd.a1);
                chk("rd_addr2", rd_addr2, m_rd.a2);
                chk("rd_addr3", rd_addr3, m_rd.a3);
            end
        end
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                chk("wr_spurious", wr_en, 0);
            end else begin
                m_wr = wr_q.pop_front();
                chk("wr_cycle", cyc, m_wr.cyc);
                chk("wr_addr", wr_addr, m_wr.addr);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                chk("done_spurious", done, 0);
            end else begin
                m_dn = done_q.pop_front();
                chk("done_cycle", cyc, m_dn.cyc);
`ifdef MAXPOOL_SEQ_PERF_EN
                chk("perf_cycles", perf_cycles, m_dn.perf);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int sb, b_nrd, b_nwr, b_done_rel;
        #2;
        reset_cycle(2);

        // Plain pass, then a start right at the earliest accepted cycle
        step(1, 0);
        repeat (9) step(0, 0);
        step(1, 0);
        repeat (12) step(0, 0);

        // Hold in cycles 2 and 3 of a pass
        step(1, 0);
        step(0, 0);
        step(0, 1);
        step(0, 1);
        repeat (10) step(0, 0);

        // Second start mid-pass is ignored
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        repeat (10) step(0, 0);

        // Start together with hold, hold released two cycles later
        step(1, 1);
        step(0, 1);
        repeat (12) step(0, 0);

        // Reset in cycle 3 of a pass, then a full clean pass
        step(1, 0);
        step(0, 0);
        step(0, 0);
        reset_cycle(1);
        repeat (4) step(0, 0);
        step(1, 0);
        repeat (12) step(0, 0);

        // Random start/hold traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (20) step(0, 0);

        // 28x28 directed pass on the second instance
        @(posedge clk);
        #1;
        start_b = 1'b1;
        sb = cyc;
        b_nrd = 0;
        b_nwr = 0;
        b_done_rel = -1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int t = 1; t <= K2 + PL + 3; t++) begin
            @(negedge clk);
            if (b_rd_en) begin
                if (b_nrd == 14) begin
                    chk("b_win14_addr0", b_rd_addr0, 56);
                    chk("b_win14_addr2", b_rd_addr2, 84);
                end
                b_nrd++;
            end
            if (b_wr_en) begin
                chk("b_wr_addr", b_wr_addr, b_nwr);
                b_nwr++;
            end
            if (b_done) b_done_rel = cyc - sb;
            @(posedge clk);
        end
        chk("b_rd_count", b_nrd, K2);
        chk("b_wr_count", b_nwr, K2);
        chk("b_done_cycle", b_done_rel, K2 + PL + 1);
        chk("b_busy_idle", b_busy, 0);
        chk("b_mp_enable_idle", b_mp_enable, 0);
        chk("b_mp_valid_idle", b_mp_valid_in, 0);
        chk("b_mp_read_idle", b_mp_read, 0);
        chk("b_rd_addr1_idle", b_rd_addr1, 0);
        chk("b_rd_addr3_idle", b_rd_addr3, 0);
`ifdef MAXPOOL_SEQ_PERF_EN
        chk("b_perf_cycles", b_perf_cycles, K2 + PL);
`endif

        chk("rd_left", rd_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        chk("done_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
